// File: rtl/ntt_ctrl_if.sv
// Control/handshake bundle between the NTT sequencer and its host/datapath.
// master = host side (drives start/inv), slave = sequencer side.
interface ntt_ctrl_if;
    logic       start;
    logic       inv;
    logic       busy;
    logic       done;
    logic [2:0] stage;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [7:0] zeta_idx;
    logic       zeta_neg;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        output start, inv,
        input  busy, done, stage,
        input  rd_en, rd_addr_a, rd_addr_b,
        input  zeta_idx, zeta_neg,
        input  wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, inv,
        output busy, done, stage,
        output rd_en, rd_addr_a, rd_addr_b,
        output zeta_idx, zeta_neg,
        output wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_ctrl.sv
// Stage/butterfly sequencer for the 256-point NTT/INTT core.
// Issues one butterfly per cycle and delays addresses into write strobes.
module ntt_ctrl #(
    parameter int PIPE_LAT = 4
) (
    input logic      clk,
    input logic      rst,
    ntt_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t     state;
    logic [2:0] s;
    logic [6:0] b;
    logic [3:0] dcnt;
    logic       inv_q;
    logic       busy_q;
    logic       done_q;
    logic       rd_en_q;
    logic [7:0] addr_a_q;
    logic [7:0] addr_b_q;
    logic [7:0] zeta_q;
    logic       neg_q;

    logic       sel_inv;
    logic [2:0] sel_s;
    logic [6:0] sel_b;
    logic [23:0] iw;

    logic [16:0] dly [PIPE_LAT];

    // Butterfly b of stage s -> {addr_a, addr_b, zeta_idx}.
    // len is a power of two, so divide/modulo reduce to shift/mask.
    function automatic logic [23:0] issue_word(
        input logic       iv,
        input logic [2:0] st,
        input logic [6:0] bf
    );
        logic [2:0] lg;
        logic [7:0] len;
        logic [7:0] g;
        logic [7:0] off;
        logic [7:0] j;
        logic [7:0] zt;
        lg  = iv ? st : 3'd7 - st;
        len = 8'd1 << lg;
        g   = {1'b0, bf} >> lg;
        off = {1'b0, bf} & (len - 8'd1);
        j   = (g << ({1'b0, lg} + 4'd1)) | off;
        zt  = iv ? 8'((9'd256 >> st) - 9'd1 - {1'b0, g})
                 : (8'd1 << st) + g;
        return {j, j + len, zt};
    endfunction

    // Pick the butterfly that will be presented in the next cycle.
    always_comb begin
        sel_inv = inv_q;
        sel_s   = s;
        sel_b   = b + 7'd1;
        case (state)
            IDLE: begin
                sel_inv = bus.inv;
                sel_s   = 3'd0;
                sel_b   = 7'd0;
            end
            DRAIN: begin
                sel_s = s + 3'd1;
                sel_b = 7'd0;
            end
            default: ;
        endcase
        iw = issue_word(sel_inv, sel_s, sel_b);
    end

    // Sequencer FSM with registered issue outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            s        <= '0;
            b        <= '0;
            dcnt     <= '0;
            inv_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            zeta_q   <= '0;
            neg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= ISSUE;
                        s       <= '0;
                        b       <= '0;
                        inv_q   <= bus.inv;
                        neg_q   <= bus.inv;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        {addr_a_q, addr_b_q, zeta_q} <= iw;
                    end
                end
                ISSUE: begin
                    if (b == 7'd127) begin
                        state   <= DRAIN;
                        rd_en_q <= 1'b0;
                        dcnt    <= '0;
                    end else begin
                        b <= b + 7'd1;
                        {addr_a_q, addr_b_q, zeta_q} <= iw;
                    end
                end
                DRAIN: begin
                    if (dcnt == 4'(PIPE_LAT - 1)) begin
                        if (s == 3'd7) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            s       <= s + 3'd1;
                            b       <= '0;
                            rd_en_q <= 1'b1;
                            {addr_a_q, addr_b_q, zeta_q} <= iw;
                        end
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-back delay line: read strobe/addresses reappear PIPE_LAT later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                dly[i] <= '0;
            end
        end else begin
            dly[0] <= {rd_en_q, addr_a_q, addr_b_q};
            for (int i = 1; i < PIPE_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.stage     = s;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = addr_a_q;
    assign bus.rd_addr_b = addr_b_q;
    assign bus.zeta_idx  = zeta_q;
    assign bus.zeta_neg  = neg_q;
    assign bus.wr_en     = dly[PIPE_LAT-1][16];
    assign bus.wr_addr_a = dly[PIPE_LAT-1][15:8];
    assign bus.wr_addr_b = dly[PIPE_LAT-1][7:0];

endmodule
